// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Instruction decode stage sitting between fetch and the execute ALU.
//   Accepts pc/insn from fetch with a valid/ready handshake and reads the
//   register file combinationally. It decodes ALUOp, the extended immediate,
//   the destination register and the load flag, then registers every field
//   for execute.
//   A load held for execute whose destination matches a source of the
//   presented instruction causes a one-cycle bubble. A branch_taken redirect
//   from execute flushes the presented instruction.
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   enable_decode           low freezes all state and deasserts if_ready
//   if_valid/if_pc/if_insn  fetch side; if_ready accepts them (combinational)
//   rf_rs_addr/rf_rt_addr   register file read addresses (insn[25:21]/[20:16])
//   rf_rs_data/rf_rt_data   register file read data, same cycle
//   ex_ready, branch_taken  execute consumes output register / redirect
//   ex_valid .. mem_read    registered decode results for execute
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int          XLEN    = 32,
    parameter logic [4:0]  RA_LINK = 5'd31
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable_decode,
    input  logic             if_valid,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [XLEN-1:0]  if_insn,
    output logic             if_ready,
    output logic [4:0]       rf_rs_addr,
    output logic [4:0]       rf_rt_addr,
    input  logic [XLEN-1:0]  rf_rs_data,
    input  logic [XLEN-1:0]  rf_rt_data,
    input  logic             ex_ready,
    input  logic             branch_taken,
    output logic             ex_valid,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  insn,
    output logic [XLEN-1:0]  rsData,
    output logic [XLEN-1:0]  rtData,
    output logic [4:0]       saData,
    output logic [XLEN-1:0]  immSXData,
    output logic [5:0]       ALUOp,
    output logic [4:0]       rd_addr,
    output logic             reg_write,
    output logic             mem_read
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_MUL   = 6'b011100;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic             ex_valid_q,  ex_valid_d;
    logic [XLEN-1:0]  pc_q,        pc_d;
    logic [XLEN-1:0]  insn_q,      insn_d;
    logic [XLEN-1:0]  rs_data_q,   rs_data_d;
    logic [XLEN-1:0]  rt_data_q,   rt_data_d;
    logic [4:0]       sa_q,        sa_d;
    logic [XLEN-1:0]  imm_q,       imm_d;
    logic [5:0]       alu_op_q,    alu_op_d;
    logic [4:0]       rd_addr_q,   rd_addr_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q,  mem_read_d;

    // ------------------------------------------------------------------
    // Combinational decode of the presented instruction
    // ------------------------------------------------------------------
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [5:0]       dec_alu_op;
    logic [XLEN-1:0]  dec_imm;
    logic [4:0]       dec_rd;
    logic             dec_we;
    logic             dec_mr;

    assign opcode     = if_insn[31:26];
    assign funct      = if_insn[5:0];
    assign rf_rs_addr = if_insn[25:21];
    assign rf_rt_addr = if_insn[20:16];

    always_comb begin
        dec_alu_op = opcode;
        dec_imm    = {{(XLEN-16){if_insn[15]}}, if_insn[15:0]};
        dec_rd     = 5'd0;
        dec_we     = 1'b0;
        dec_mr     = 1'b0;

        // R-type and SPECIAL2 MUL carry their operation in the funct field
        if (opcode == OP_RTYPE || opcode == OP_MUL) begin
            dec_alu_op = funct;
        end

        // Logical immediates are unsigned; everything else sign-extends
        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI) begin
            dec_imm = {{(XLEN-16){1'b0}}, if_insn[15:0]};
        end

        case (opcode)
            OP_RTYPE: begin
                if (funct != FN_JR) begin
                    dec_rd = if_insn[15:11];
                    dec_we = 1'b1;
                end
            end
            // MUL is R-format and writes rd like any other R-type op
            OP_MUL: begin
                dec_rd = if_insn[15:11];
                dec_we = 1'b1;
            end
            OP_JAL: begin
                dec_rd = RA_LINK;
                dec_we = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_LW, OP_LB, OP_LBU: begin
                dec_rd = if_insn[20:16];
                dec_we = 1'b1;
            end
            default: begin
                dec_rd = 5'd0;
                dec_we = 1'b0;
            end
        endcase

        // $zero is never a real destination
        if (dec_rd == 5'd0) begin
            dec_we = 1'b0;
        end

        dec_mr = (opcode == OP_LW) || (opcode == OP_LB) || (opcode == OP_LBU);
    end

    // ------------------------------------------------------------------
    // Hazard and handshake
    // ------------------------------------------------------------------
    logic hazard;
    logic load;

    // Load result is not available until after execute/memory, so a consumer
    // immediately behind a load must wait one cycle.
    assign hazard = ex_valid_q & mem_read_q & reg_write_q & if_valid &
                    ((rd_addr_q == if_insn[25:21]) | (rd_addr_q == if_insn[20:16]));

    assign load = enable_decode & (~ex_valid_q | ex_ready);

    // On a redirect the presented instruction is wrong-path: consume it even
    // if it would otherwise have stalled on a hazard, then drop it.
    assign if_ready = load & (branch_taken | ~hazard);

    // ------------------------------------------------------------------
    // Next-state logic for the output register
    // ------------------------------------------------------------------
    always_comb begin
        ex_valid_d  = ex_valid_q;
        pc_d        = pc_q;
        insn_d      = insn_q;
        rs_data_d   = rs_data_q;
        rt_data_d   = rt_data_q;
        sa_d        = sa_q;
        imm_d       = imm_q;
        alu_op_d    = alu_op_q;
        rd_addr_d   = rd_addr_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;

        if (enable_decode) begin
            if (branch_taken) begin
                // Flush even while execute is stalled: its contents are wrong-path
                ex_valid_d = 1'b0;
            end else if (load) begin
                if (hazard) begin
                    ex_valid_d = 1'b0;
                end else if (if_valid) begin
                    ex_valid_d  = 1'b1;
                    pc_d        = if_pc;
                    insn_d      = if_insn;
                    rs_data_d   = rf_rs_data;
                    rt_data_d   = rf_rt_data;
                    sa_d        = if_insn[10:6];
                    imm_d       = dec_imm;
                    alu_op_d    = dec_alu_op;
                    rd_addr_d   = dec_rd;
                    reg_write_d = dec_we;
                    mem_read_d  = dec_mr;
                end else begin
                    ex_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q  <= 1'b0;
            pc_q        <= '0;
            insn_q      <= '0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            sa_q        <= '0;
            imm_q       <= '0;
            alu_op_q    <= '0;
            rd_addr_q   <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            pc_q        <= pc_d;
            insn_q      <= insn_d;
            rs_data_q   <= rs_data_d;
            rt_data_q   <= rt_data_d;
            sa_q        <= sa_d;
            imm_q       <= imm_d;
            alu_op_q    <= alu_op_d;
            rd_addr_q   <= rd_addr_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign pc        = pc_q;
    assign insn      = insn_q;
    assign rsData    = rs_data_q;
    assign rtData    = rt_data_q;
    assign saData    = sa_q;
    assign immSXData = imm_q;
    assign ALUOp     = alu_op_q;
    assign rd_addr   = rd_addr_q;
    assign reg_write = reg_write_q;
    assign mem_read  = mem_read_q;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Table of directed instructions with hand-computed decode results, applied
//   back to back, followed by hand-written sequences for load-use bubble,
//   branch flush, execute stall, enable freeze and asynchronous reset.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        enable_decode = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_insn = '0;
    logic        if_ready;
    logic [4:0]  rf_rs_addr;
    logic [4:0]  rf_rt_addr;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic        ex_ready = 1'b1;
    logic        branch_taken = 1'b0;
    logic        ex_valid;
    logic [31:0] pc;
    logic [31:0] insn;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [4:0]  saData;
    logic [31:0] immSXData;
    logic [5:0]  ALUOp;
    logic [4:0]  rd_addr;
    logic        reg_write;
    logic        mem_read;

    int checks = 0;
    int failures = 0;

    // Register file model: r0=0, r1=5, r2=7, otherwise 0x1000+index
    logic [31:0] rf_mem [32];
    assign rf_rs_data = rf_mem[rf_rs_addr];
    assign rf_rt_data = rf_mem[rf_rt_addr];

    always #5 clock = ~clock;

    decode_stage dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable_decode(enable_decode),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_insn      (if_insn),
        .if_ready     (if_ready),
        .rf_rs_addr   (rf_rs_addr),
        .rf_rt_addr   (rf_rt_addr),
        .rf_rs_data   (rf_rs_data),
        .rf_rt_data   (rf_rt_data),
        .ex_ready     (ex_ready),
        .branch_taken (branch_taken),
        .ex_valid     (ex_valid),
        .pc           (pc),
        .insn         (insn),
        .rsData       (rsData),
        .rtData       (rtData),
        .saData       (saData),
        .immSXData    (immSXData),
        .ALUOp        (ALUOp),
        .rd_addr      (rd_addr),
        .reg_write    (reg_write),
        .mem_read     (mem_read)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] insn;
        logic [31:0] rs_exp;
        logic [31:0] rt_exp;
        logic [31:0] imm_exp;
        logic [5:0]  alu_exp;
        logic [4:0]  sa_exp;
        logic [4:0]  rd_exp;
        logic        we_exp;
        logic        mr_exp;
        logic        chk_wb;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    localparam logic [31:0] I_LW   = 32'h8C220000; // LW  $2,0($1)
    localparam logic [31:0] I_ADD  = 32'h00432020; // ADD $4,$2,$3
    localparam logic [31:0] I_ORI  = 32'h3408FFFC; // ORI $8,$0,0xFFFC
    localparam logic [31:0] I_JAL  = 32'h0C000010;
    localparam logic [31:0] I_ADDU = 32'h00221821; // ADDU $3,$1,$2

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        for (int r = 0; r < 32; r++) rf_mem[r] = 32'h1000 + r;
        rf_mem[0] = 32'h0;
        rf_mem[1] = 32'd5;
        rf_mem[2] = 32'd7;

        //        name    insn          rs          rt          imm         alu    sa  rd  we mr chk
        vecs[0]  = '{"addu", 32'h00221821, 32'd5,      32'd7,      32'h00001821, 6'h21, 5'd0,  5'd3,  1, 0, 1};
        vecs[1]  = '{"addi", 32'h2008FFFC, 32'd0,      32'h1008,   32'hFFFFFFFC, 6'h08, 5'd31, 5'd8,  1, 0, 1};
        vecs[2]  = '{"ori",  32'h3408FFFC, 32'd0,      32'h1008,   32'h0000FFFC, 6'h0D, 5'd31, 5'd8,  1, 0, 1};
        vecs[3]  = '{"jal",  32'h0C000010, 32'd0,      32'd0,      32'h00000010, 6'h03, 5'd0,  5'd31, 1, 0, 1};
        vecs[4]  = '{"add0", 32'h00220020, 32'd5,      32'd7,      32'h00000020, 6'h20, 5'd0,  5'd0,  0, 0, 1};
        vecs[5]  = '{"sw",   32'hACC50004, 32'h1006,   32'h1005,   32'h00000004, 6'h2B, 5'd0,  5'd0,  0, 0, 1};
        vecs[6]  = '{"lb",   32'h8069FFFF, 32'h1003,   32'h1009,   32'hFFFFFFFF, 6'h20, 5'd31, 5'd9,  1, 1, 1};
        vecs[7]  = '{"sll",  32'h000B5100, 32'd0,      32'h100B,   32'h00005100, 6'h00, 5'd4,  5'd10, 1, 0, 1};
        vecs[8]  = '{"jr",   32'h03E00008, 32'h101F,   32'd0,      32'h00000008, 6'h08, 5'd0,  5'd0,  0, 0, 1};
        vecs[9]  = '{"mul",  32'h70A62002, 32'h1005,   32'h1006,   32'h00002002, 6'h02, 5'd0,  5'd4,  1, 0, 0};
        vecs[10] = '{"xori", 32'h39AC8000, 32'h100D,   32'h100C,   32'h00008000, 6'h0E, 5'd0,  5'd12, 1, 0, 1};
        vecs[11] = '{"lbu",  32'h90870002, 32'h1004,   32'h1007,   32'h00000002, 6'h24, 5'd0,  5'd7,  1, 1, 1};

        // ---------------- reset state ----------------
        #1 reset_n = 1'b0;
        #2;
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_insn", insn, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_ex_valid", {31'd0, ex_valid}, 32'd0);

        // ---------------- table-driven decode ----------------
        if_valid = 1'b1;
        if_insn  = vecs[0].insn;
        if_pc    = 32'h400;
        for (int i = 0; i < NV; i++) begin
            #1 chk({vecs[i].name, "_if_ready"}, {31'd0, if_ready}, 32'd1);
            @(negedge clock);
            chk({vecs[i].name, "_ex_valid"}, {31'd0, ex_valid}, 32'd1);
            chk({vecs[i].name, "_pc"},     pc, 32'h400 + 32'(4 * i));
            chk({vecs[i].name, "_insn"},   insn, vecs[i].insn);
            chk({vecs[i].name, "_rs"},     rsData, vecs[i].rs_exp);
            chk({vecs[i].name, "_rt"},     rtData, vecs[i].rt_exp);
            chk({vecs[i].name, "_imm"},    immSXData, vecs[i].imm_exp);
            chk({vecs[i].name, "_aluop"},  {26'd0, ALUOp}, {26'd0, vecs[i].alu_exp});
            chk({vecs[i].name, "_sa"},     {27'd0, saData}, {27'd0, vecs[i].sa_exp});
            chk({vecs[i].name, "_memrd"},  {31'd0, mem_read}, {31'd0, vecs[i].mr_exp});
            if (vecs[i].chk_wb) begin
                chk({vecs[i].name, "_regwr"}, {31'd0, reg_write}, {31'd0, vecs[i].we_exp});
                if (vecs[i].we_exp)
                    chk({vecs[i].name, "_rd"}, {27'd0, rd_addr}, {27'd0, vecs[i].rd_exp});
            end
            $display("vec %0d %s insn=%08h aluop=%02h imm=%08h rd=%0d we=%0b", i, vecs[i].name,
                     insn, ALUOp, immSXData, rd_addr, reg_write);
            if (i < NV - 1) begin
                if_insn = vecs[i+1].insn;
                if_pc   = 32'h400 + 32'(4 * (i + 1));
            end else begin
                if_valid = 1'b0;
            end
        end

        // ---------------- load-use bubble ----------------
        @(negedge clock);
        if_valid = 1'b1; if_insn = I_LW; if_pc = 32'h500;
        #1 chk("lw_if_ready", {31'd0, if_ready}, 32'd1);
        @(negedge clock);
        chk("lw_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("lw_rd", {27'd0, rd_addr}, 32'd2);
        if_insn = I_ADD; if_pc = 32'h504;
        #1 chk("hazard_if_ready", {31'd0, if_ready}, 32'd0);
        @(negedge clock);
        chk("bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
        #1 chk("after_bubble_if_ready", {31'd0, if_ready}, 32'd1);
        @(negedge clock);
        chk("add_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("add_insn", insn, I_ADD);
        chk("add_rs", rsData, 32'd7);
        chk("add_rt", rtData, 32'h1003);
        $display("loaduse insn=%08h ex_valid=%0b", insn, ex_valid);

        // ---------------- branch flush ----------------
        if_insn = I_ORI; if_pc = 32'h508; branch_taken = 1'b1;
        #1 chk("br_if_ready", {31'd0, if_ready}, 32'd1);
        @(negedge clock);
        branch_taken = 1'b0; if_valid = 1'b0;
        chk("br_ex_valid", {31'd0, ex_valid}, 32'd0);
        @(negedge clock);
        chk("br_dropped_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("br_dropped_insn", insn, I_ADD);
        $display("flush ex_valid=%0b insn=%08h", ex_valid, insn);

        // Redirect overrides a pending load-use stall
        if_valid = 1'b1; if_insn = I_LW; if_pc = 32'h600;
        @(negedge clock);
        if_insn = I_ADD; branch_taken = 1'b1;
        #1 chk("br_haz_if_ready", {31'd0, if_ready}, 32'd1);
        @(negedge clock);
        branch_taken = 1'b0; if_valid = 1'b0;
        chk("br_haz_ex_valid", {31'd0, ex_valid}, 32'd0);
        $display("flush-over-hazard ex_valid=%0b", ex_valid);

        // ---------------- execute stall ----------------
        @(negedge clock);
        if_valid = 1'b1; if_insn = I_JAL; if_pc = 32'h700;
        @(negedge clock);
        chk("jal_rd", {27'd0, rd_addr}, 32'd31);
        chk("jal_we", {31'd0, reg_write}, 32'd1);
        ex_ready = 1'b0; if_insn = I_ADDU; if_pc = 32'h704;
        for (int s = 0; s < 3; s++) begin
            #1 chk("stall_if_ready", {31'd0, if_ready}, 32'd0);
            @(negedge clock);
            chk("stall_ex_valid", {31'd0, ex_valid}, 32'd1);
            chk("stall_insn", insn, I_JAL);
            chk("stall_pc", pc, 32'h700);
            $display("stall %0d insn=%08h", s, insn);
        end
        ex_ready = 1'b1;
        #1 chk("unstall_if_ready", {31'd0, if_ready}, 32'd1);
        @(negedge clock);
        chk("unstall_insn", insn, I_ADDU);
        chk("unstall_rs", rsData, 32'd5);

        // ---------------- enable freeze (ignores branch_taken) ----------------
        enable_decode = 1'b0; branch_taken = 1'b1; if_insn = I_ORI;
        #1 chk("dis_if_ready", {31'd0, if_ready}, 32'd0);
        @(negedge clock);
        chk("dis_ex_valid", {31'd0, ex_valid}, 32'd1);
        chk("dis_insn", insn, I_ADDU);
        $display("freeze ex_valid=%0b insn=%08h", ex_valid, insn);
        enable_decode = 1'b1; branch_taken = 1'b0; if_valid = 1'b0;

        // ---------------- asynchronous reset mid-stream ----------------
        #2 reset_n = 1'b0;
        #1;
        chk("arst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_insn", insn, 32'd0);
        chk("arst_pc", pc, 32'd0);
        chk("arst_rs", rsData, 32'd0);
        chk("arst_regwr", {31'd0, reg_write}, 32'd0);
        $display("async reset ex_valid=%0b insn=%08h", ex_valid, insn);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_ex_valid", {31'd0, ex_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
